// File: rtl/rr_priority_encoder_pkg.sv
// Shared types and constants for the round-robin priority encoder.
// The state enum, default width and a clog2 helper live here.
package rr_priority_encoder_pkg;

  localparam int DEFAULT_N = 4;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int v = value - 1; v > 0; v = v >> 1) begin
      result = result + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/rr_priority_encoder_rr_pick.sv
// Combinational round-robin selector: lowest set bit at or above ptr_i,
// falling back to the lowest set bit overall when nothing lies above.
module rr_pick
  import rr_priority_encoder_pkg::*;
#(
  parameter int N = DEFAULT_N,
  localparam int W = clog2(N)
) (
  input  logic [N-1:0] pending_i,
  input  logic [W-1:0] ptr_i,
  output logic         found_o,
  output logic [W-1:0] idx_o
);

  logic [N-1:0] upper_mask;
  logic [N-1:0] upper_req;

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_mask
      assign upper_mask[gi] = (W'(gi) >= ptr_i);
    end
  endgenerate

  assign upper_req = pending_i & upper_mask;
  assign found_o   = |pending_i;

  // The second scan overrides the first, so a hit at or above ptr always wins.
  always_comb begin
    idx_o = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (pending_i[i]) idx_o = W'(i);
    end
    for (int i = N - 1; i >= 0; i--) begin
      if (upper_req[i]) idx_o = W'(i);
    end
  end

endmodule

// File: rtl/rr_priority_encoder.sv
// Round-robin priority encoder: takes an N-bit request vector and emits the
// index of each set bit, one per accepted beat, with fairness kept across vectors.
module rr_priority_encoder
  import rr_priority_encoder_pkg::*;
#(
  parameter int N = DEFAULT_N,
  localparam int W = clog2(N)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req_valid,
  output logic         req_ready,
  input  logic [N-1:0] req_vec,
  output logic         code_valid,
  input  logic         code_ready,
  output logic [W-1:0] code,
  output logic [N-1:0] code_onehot,
  output logic         code_last,
  output logic         zero_drop
);

  state_e       state_q, state_d;
  logic [N-1:0] pending_q, pending_d;
  logic [W-1:0] ptr_q, ptr_d;
  logic         zero_drop_q, zero_drop_d;

  logic         pick_found;
  logic [W-1:0] pick_idx;
  logic         single_bit;
  logic [N-1:0] pick_onehot;

  rr_pick #(.N(N)) u_pick (
    .pending_i (pending_q),
    .ptr_i     (ptr_q),
    .found_o   (pick_found),
    .idx_o     (pick_idx)
  );

  assign single_bit  = (pending_q != '0) && ((pending_q & (pending_q - N'(1))) == '0);
  assign pick_onehot = N'(1) << pick_idx;

  // Outputs depend only on registered state, never on inputs.
  always_comb begin
    req_ready   = (state_q == IDLE);
    code_valid  = (state_q == BUSY);
    code        = code_valid ? pick_idx : '0;
    code_onehot = code_valid ? pick_onehot : '0;
    code_last   = code_valid && single_bit;
    zero_drop   = zero_drop_q;
  end

  always_comb begin
    state_d     = state_q;
    pending_d   = pending_q;
    ptr_d       = ptr_q;
    zero_drop_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          if (req_vec != '0) begin
            pending_d = req_vec;
            state_d   = BUSY;
          end else begin
            zero_drop_d = 1'b1;
          end
        end
      end
      BUSY: begin
        if (code_ready && pick_found) begin
          pending_d = pending_q & ~pick_onehot;
          // N is a power of two, so the W-bit add wraps N-1 back to 0.
          ptr_d     = pick_idx + W'(1);
          if (single_bit) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      pending_q   <= '0;
      ptr_q       <= '0;
      zero_drop_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      pending_q   <= pending_d;
      ptr_q       <= ptr_d;
      zero_drop_q <= zero_drop_d;
    end
  end

endmodule
